// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception-controller bus: register access, exception entry/return and status outputs.
// master = pipeline side (drives requests), slave = the CP0 block.
// NUM_HWINT must match the NUM_HWINT of the cp0_exc_ctrl instance it connects to.
interface cp0_exc_ctrl_if #(
   parameter int NUM_HWINT = 6
);
   logic [NUM_HWINT-1:0] hwint;
   logic [4:0]           sel;
   logic                 wen;
   logic [31:0]          din;
   logic [31:0]          epc_in;
   logic                 exc_req;
   logic [4:0]           exc_code;
   logic                 eret;
   logic [31:0]          dout;
   logic [31:0]          epc_out;
   logic                 intreq;
   logic                 exc_take;

   modport master (
      output hwint, sel, wen, din, epc_in, exc_req, exc_code, eret,
      input  dout, epc_out, intreq, exc_take
   );

   modport slave (
      input  hwint, sel, wen, din, epc_in, exc_req, exc_code, eret,
      output dout, epc_out, intreq, exc_take
   );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId; optional Count/Compare timer
// when CP0_EXC_CTRL_TIMER_EN is defined. Reads are combinational, updates on rising clk;
// hwint reaches Cause.IP one cycle later. No backpressure: entry is accepted whenever EXL=0.
module cp0_exc_ctrl #(
   parameter int          NUM_HWINT  = 6,
   parameter logic [31:0] PRID_VALUE = 32'h18061225
) (
   input logic          clk,
   input logic          rst,
   cp0_exc_ctrl_if.slave bus
);

   localparam logic [4:0] SEL_COUNT   = 5'd9;
   localparam logic [4:0] SEL_COMPARE = 5'd11;
   localparam logic [4:0] SEL_SR      = 5'd12;
   localparam logic [4:0] SEL_CAUSE   = 5'd13;
   localparam logic [4:0] SEL_EPC     = 5'd14;
   localparam logic [4:0] SEL_PRID    = 5'd15;

   logic [5:0]           im;
   logic                 exl;
   logic                 ie;
   logic [NUM_HWINT-1:0] ip_hw;
   logic [4:0]           exc_code_q;
   logic [31:0]          epc;
   logic [5:0]           ip;
   logic                 intreq;
   logic                 take;
   logic                 wr_sr;
   logic                 wr_epc;

`ifdef CP0_EXC_CTRL_TIMER_EN
   logic [31:0]          count;
   logic [31:0]          compare;
   logic                 timer_pend;
`endif

   assign wr_sr  = bus.wen && (bus.sel == SEL_SR);
   assign wr_epc = bus.wen && (bus.sel == SEL_EPC);

   // Visible IP field: registered hardware lines, timer pending folded into the top line.
   always_comb begin
      ip = '0;
      ip[NUM_HWINT-1:0] = ip_hw;
`ifdef CP0_EXC_CTRL_TIMER_EN
      ip[NUM_HWINT-1] = ip_hw[NUM_HWINT-1] | timer_pend;
`endif
   end

   // Interrupt request and entry acceptance come purely from registered state plus exc_req.
   assign intreq = (|(ip & im)) & ie & ~exl;
   assign take   = (intreq | bus.exc_req) & ~exl;

   assign bus.intreq   = intreq;
   assign bus.exc_take = take;
   assign bus.epc_out  = epc;

   // Main CP0 state: entry overrides mtc0 for EPC/EXL, eret overrides mtc0 for EXL.
   always_ff @(posedge clk) begin
      if (rst) begin
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         ip_hw      <= '0;
         exc_code_q <= '0;
         epc        <= '0;
      end else begin
         ip_hw <= bus.hwint;
         if (wr_sr) begin
            im  <= bus.din[15:10];
            exl <= bus.din[1];
            ie  <= bus.din[0];
         end
         if (wr_epc) begin
            epc <= bus.din;
         end
         if (bus.eret) begin
            exl <= 1'b0;
         end
         if (take) begin
            epc        <= bus.epc_in;
            exl        <= 1'b1;
            exc_code_q <= intreq ? 5'd0 : bus.exc_code;
         end
      end
   end

`ifdef CP0_EXC_CTRL_TIMER_EN
   // Free-running Count, Compare, and a sticky match flag that only a Compare write clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         compare    <= '0;
         timer_pend <= 1'b0;
      end else begin
         if (bus.wen && (bus.sel == SEL_COUNT)) begin
            count <= bus.din;
         end else begin
            count <= count + 32'd1;
         end
         if (bus.wen && (bus.sel == SEL_COMPARE)) begin
            compare    <= bus.din;
            timer_pend <= 1'b0;
         end else if (count == compare) begin
            timer_pend <= 1'b1;
         end
      end
   end
`endif

   // Combinational register read; unimplemented selects return zero.
   always_comb begin
      bus.dout = '0;
      case (bus.sel)
         SEL_SR:    bus.dout = {16'h0, im, 8'h0, exl, ie};
         SEL_CAUSE: bus.dout = {16'h0, ip, 3'b000, exc_code_q, 2'b00};
         SEL_EPC:   bus.dout = epc;
         SEL_PRID:  bus.dout = PRID_VALUE;
`ifdef CP0_EXC_CTRL_TIMER_EN
         SEL_COUNT:   bus.dout = count;
         SEL_COMPARE: bus.dout = compare;
`endif
         default:   bus.dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: vector table plus short multi-cycle sequences.
// Inputs change 1 time unit after the rising edge, outputs are checked on the falling edge.
// With CP0_EXC_CTRL_TIMER_EN defined only the timer sequence runs.
module tb_cp0_exc_ctrl;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   cp0_exc_ctrl_if #(.NUM_HWINT(6)) bus ();

   cp0_exc_ctrl #(.NUM_HWINT(6), .PRID_VALUE(32'h18061225)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [5:0]  hwint;
      logic [4:0]  sel;
      logic        wen;
      logic [31:0] din;
      logic [31:0] epc_in;
      logic        exc_req;
      logic [4:0]  exc_code;
      logic        eret;
      logic [31:0] e_dout;
      logic        e_intreq;
      logic        e_take;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [5:0] hw, input logic [4:0] s,
                               input logic w, input logic [31:0] d, input logic [31:0] pc,
                               input logic er, input logic [4:0] code, input logic ret,
                               input logic [31:0] edout, input logic eirq, input logic etake,
                               input logic [31:0] eepc);
      vec_t v;
      v.rst = r; v.hwint = hw; v.sel = s; v.wen = w; v.din = d; v.epc_in = pc;
      v.exc_req = er; v.exc_code = code; v.eret = ret;
      v.e_dout = edout; v.e_intreq = eirq; v.e_take = etake; v.e_epc = eepc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst          = v.rst;
      bus.hwint    = v.hwint;
      bus.sel      = v.sel;
      bus.wen      = v.wen;
      bus.din      = v.din;
      bus.epc_in   = v.epc_in;
      bus.exc_req  = v.exc_req;
      bus.exc_code = v.exc_code;
      bus.eret     = v.eret;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      chk({tag, ".dout"},     bus.dout,            v.e_dout);
      chk({tag, ".intreq"},   {31'd0, bus.intreq},   {31'd0, v.e_intreq});
      chk({tag, ".exc_take"}, {31'd0, bus.exc_take}, {31'd0, v.e_take});
      chk({tag, ".epc_out"},  bus.epc_out,         v.e_epc);
   endtask

`ifdef CP0_EXC_CTRL_TIMER_EN
   task automatic wr(input logic [4:0] s, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.sel = s; bus.din = d; bus.wen = 1'b1;
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.hwint = '0; bus.sel = '0; bus.wen = 1'b0; bus.din = '0;
      bus.epc_in = '0; bus.exc_req = 1'b0; bus.exc_code = '0; bus.eret = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

`ifndef CP0_EXC_CTRL_TIMER_EN
      // reset state, read-only and unimplemented selects
      tbl.push_back(mk(0, 6'd0, 15, 0, 32'h0,        32'h0,    0, 0,  0, 32'h18061225, 0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 12, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 14, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 10, 1, 32'hFFFFFFFF, 32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0,  9, 1, 32'hFFFFFFFF, 32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 10, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0,  9, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      // interrupt entry: SR=0x401, hwint[0]
      tbl.push_back(mk(0, 6'd1, 12, 1, 32'h401,      32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd1, 12, 0, 32'h0,        32'h3010, 0, 0,  0, 32'h401,      1, 1, 32'h0));
      tbl.push_back(mk(0, 6'd1, 13, 0, 32'h0,        32'h0,    0, 0,  0, 32'h400,      0, 0, 32'h3010));
      tbl.push_back(mk(0, 6'd1, 12, 0, 32'h0,        32'h0,    0, 0,  0, 32'h403,      0, 0, 32'h3010));
      // eret with interrupt still held: re-entry the following cycle
      tbl.push_back(mk(0, 6'd1, 12, 0, 32'h0,        32'h0,    0, 0,  1, 32'h403,      0, 0, 32'h3010));
      tbl.push_back(mk(0, 6'd1, 12, 0, 32'h0,        32'h3040, 0, 0,  0, 32'h401,      1, 1, 32'h3010));
      // SR=0 clears EXL, then synchronous exception and a blocked nested one
      tbl.push_back(mk(0, 6'd0, 12, 1, 32'h0,        32'h0,    0, 0,  0, 32'h403,      0, 0, 32'h3040));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h3020, 1, 10, 0, 32'h0,        0, 1, 32'h3040));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h3030, 1, 7,  0, 32'h28,       0, 0, 32'h3020));
      tbl.push_back(mk(0, 6'd0, 14, 0, 32'h0,        32'h0,    0, 0,  0, 32'h3020,     0, 0, 32'h3020));
      // mtc0 SR together with eret: EXL cleared, IM/IE from din
      tbl.push_back(mk(0, 6'd0, 12, 1, 32'h403,      32'h0,    0, 0,  1, 32'h2,        0, 0, 32'h3020));
      tbl.push_back(mk(0, 6'd0, 12, 0, 32'h0,        32'h0,    0, 0,  0, 32'h401,      0, 0, 32'h3020));
      // interrupt and exc_req in the same cycle: interrupt wins, ExcCode=0
      tbl.push_back(mk(0, 6'd1, 12, 0, 32'h0,        32'h0,    0, 0,  0, 32'h401,      0, 0, 32'h3020));
      tbl.push_back(mk(0, 6'd1, 13, 0, 32'h0,        32'h3050, 1, 12, 0, 32'h428,      1, 1, 32'h3020));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h0,    0, 0,  0, 32'h400,      0, 0, 32'h3050));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h0,    0, 0,  1, 32'h0,        0, 0, 32'h3050));
      // mtc0 EPC together with entry: entry wins for EPC
      tbl.push_back(mk(0, 6'd0, 14, 1, 32'hDEADBEEF, 32'h3060, 1, 4,  0, 32'h3050,     0, 1, 32'h3050));
      tbl.push_back(mk(0, 6'd0, 14, 0, 32'h0,        32'h0,    0, 0,  0, 32'h3060,     0, 0, 32'h3060));
      tbl.push_back(mk(0, 6'd0, 14, 1, 32'hDEADBEEF, 32'h0,    0, 0,  0, 32'h3060,     0, 0, 32'h3060));
      tbl.push_back(mk(0, 6'd0, 14, 0, 32'h0,        32'h0,    0, 0,  0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF));
      // PRId and Cause ignore mtc0
      tbl.push_back(mk(0, 6'd0, 15, 1, 32'h0,        32'h0,    0, 0,  0, 32'h18061225, 0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 6'd0, 13, 1, 32'hFFFFFFFF, 32'h0,    0, 0,  0, 32'h10,       0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h0,    0, 0,  0, 32'h10,       0, 0, 32'hDEADBEEF));
      // reset mid-handler overrides mtc0 EPC, exc_req and eret
      tbl.push_back(mk(1, 6'd0, 14, 1, 32'h12345678, 32'h0,    1, 3,  1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 6'd0, 14, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 12, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(0, 6'd0, 13, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,        0, 0, 32'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // highest hardware line: one-cycle IP latency, then entry
      run_vec(mk(0, 6'h20, 12, 1, 32'hFC01, 32'h0,    0, 0, 0, 32'h0,    0, 0, 32'h0), "hw5_set");
      run_vec(mk(0, 6'h20, 13, 0, 32'h0,    32'h3070, 0, 0, 0, 32'h8000, 1, 1, 32'h0), "hw5_irq");
      run_vec(mk(0, 6'h20, 12, 0, 32'h0,    32'h0,    0, 0, 0, 32'hFC03, 0, 0, 32'h3070), "hw5_exl");
      // reset with a concurrent exc_req leaves no handler state behind
      run_vec(mk(1, 6'h00, 12, 0, 32'h0,    32'h3080, 1, 9, 0, 32'hFC03, 0, 0, 32'h3070), "rst_exc");
      run_vec(mk(0, 6'h00, 12, 0, 32'h0,    32'h0,    0, 0, 0, 32'h0,    0, 0, 32'h0),    "rst_sr");
      run_vec(mk(0, 6'h00, 13, 0, 32'h0,    32'h0,    0, 0, 0, 32'h0,    0, 0, 32'h0),    "rst_cause");
`else
      begin
         bit seen;
         seen = 1'b0;
         wr(5'd11, 32'd5);
         wr(5'd9,  32'd0);
         wr(5'd12, 32'h8001);
         @(posedge clk);
         #1;
         bus.wen = 1'b0;
         bus.sel = 5'd9;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.intreq) seen = 1'b1;
            else begin
               @(posedge clk);
               #1;
            end
         end
         chk("tmr_irq_seen", {31'd0, seen}, 32'd1);
         chk("tmr_count", bus.dout, 32'd6);
         @(posedge clk);
         #1;
         bus.sel = 5'd13;
         @(negedge clk);
         chk("tmr_pend_sticky", bus.dout, 32'h8000);
         wr(5'd11, 32'd100);
         @(posedge clk);
         #1;
         bus.wen = 1'b0;
         bus.sel = 5'd13;
         @(negedge clk);
         chk("tmr_pend_clr", bus.dout, 32'h0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
